// File: rtl/accel_pkg.sv
// rtl/accel_pkg.sv - shared accelerator widths, saturation limits and requantize function
// Optional build macro: PSUM_DRAIN_ROUND_EN (round-half-up before the shift; truncation otherwise).
package accel_pkg;

    localparam int DEF_COLS   = 8;
    localparam int DEF_PSUM_W = 24;
    localparam int DEF_OUT_W  = 8;
    localparam int DEF_DEPTH  = 4;

    localparam logic signed [DEF_OUT_W-1:0]  SAT_MAX     = DEF_OUT_W'(2**(DEF_OUT_W-1) - 1);
    localparam logic signed [DEF_OUT_W-1:0]  SAT_MIN     = DEF_OUT_W'(-(2**(DEF_OUT_W-1)));
    localparam logic signed [DEF_PSUM_W:0]   SAT_MAX_EXT = (DEF_PSUM_W+1)'(2**(DEF_OUT_W-1) - 1);
    localparam logic signed [DEF_PSUM_W:0]   SAT_MIN_EXT = (DEF_PSUM_W+1)'(-(2**(DEF_OUT_W-1)));

    // Arithmetic right shift then saturate; one extra bit keeps the rounding add from wrapping.
    function automatic logic signed [DEF_OUT_W-1:0] requant(
        input logic signed [DEF_PSUM_W-1:0] psum,
        input logic        [4:0]            shamt
    );
        logic signed [DEF_PSUM_W:0] ext;
        logic signed [DEF_PSUM_W:0] v;
        ext = {psum[DEF_PSUM_W-1], psum};
`ifdef PSUM_DRAIN_ROUND_EN
        if (shamt != 5'd0) begin
            ext = ext + ((DEF_PSUM_W+1)'(1) << (shamt - 5'd1));
        end
`endif
        v = ext >>> shamt;
        if (v > SAT_MAX_EXT) begin
            return SAT_MAX;
        end else if (v < SAT_MIN_EXT) begin
            return SAT_MIN;
        end
        return v[DEF_OUT_W-1:0];
    endfunction

endpackage

// File: rtl/psum_fifo.sv
// rtl/psum_fifo.sv - synchronous row FIFO with count and registered head
// Ports: clk, rst_n (async active-low), clear (sync flush), push/push_data,
//        pop, head_data (registered head row), empty, full, count (0..DEPTH).
module psum_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;
    logic [CW-1:0]    count_rem;
    logic [WIDTH-1:0] head_next;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign do_pop    = pop && !empty;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_push   = push && (!full || do_pop);
    assign count_rem = count - CW'(do_pop);

    // Next head: the surviving entry behind the pop, or the pushed row when nothing survives.
    always_comb begin
        head_next = '0;
        if (count_rem != '0) begin
            head_next = mem[rd_ptr + AW'(do_pop)];
        end else if (do_push) begin
            head_next = push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            head_data <= '0;
        end else if (clear) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            head_data <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            count     <= count_rem + CW'(do_push);
            head_data <= head_next;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/psum_drain.sv
// rtl/psum_drain.sv - collects skewed column partial sums into rows, requantizes and queues them
// Ports: clk, rst_n (async active-low), clear, shift_amt, col_valid/col_psum (per-column capture),
//        out_valid/out_ready/out_data (row handshake), stall_req, overflow, dup_err (sticky).
// Optional build macro: PSUM_DRAIN_ROUND_EN (selects round-half-up in accel_pkg::requant).
module psum_drain
    import accel_pkg::*;
#(
    parameter int COLS   = DEF_COLS,
    parameter int PSUM_W = DEF_PSUM_W,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic [4:0]               shift_amt,
    input  logic [COLS-1:0]          col_valid,
    input  logic [COLS*PSUM_W-1:0]   col_psum,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [COLS*OUT_W-1:0]    out_data,
    output logic                     stall_req,
    output logic                     overflow,
    output logic                     dup_err
);

    localparam int CW = $clog2(DEPTH+1);

    logic [COLS-1:0]        mask;
    logic [COLS-1:0]        take;
    logic [PSUM_W-1:0]      row_buf [COLS];
    logic [PSUM_W-1:0]      merged  [COLS];
    logic                   row_done;
    logic                   q_valid;
    logic [COLS*OUT_W-1:0]  q_row;
    logic [COLS*OUT_W-1:0]  q_next;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   pop;
    logic [CW-1:0]          count;

    assign take     = col_valid & ~mask;
    assign row_done = &(mask | col_valid);
    assign pop      = out_valid && out_ready;

    // Quantize the row as it will look after this edge's captures.
    always_comb begin
        for (int c = 0; c < COLS; c++) begin
            merged[c] = take[c] ? col_psum[c*PSUM_W +: PSUM_W] : row_buf[c];
            q_next[c*OUT_W +: OUT_W] = requant(merged[c], shift_amt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask     <= '0;
            q_valid  <= 1'b0;
            q_row    <= '0;
            dup_err  <= 1'b0;
            overflow <= 1'b0;
            for (int c = 0; c < COLS; c++) begin
                row_buf[c] <= '0;
            end
        end else if (clear) begin
            mask    <= '0;
            q_valid <= 1'b0;
        end else begin
            if ((col_valid & mask) != '0) begin
                dup_err <= 1'b1;
            end
            // Drop happens exactly when the FIFO refuses the push.
            if (q_valid && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
            q_valid <= row_done;
            if (row_done) begin
                mask  <= '0;
                q_row <= q_next;
            end else begin
                mask <= mask | take;
            end
            for (int c = 0; c < COLS; c++) begin
                if (take[c]) begin
                    row_buf[c] <= col_psum[c*PSUM_W +: PSUM_W];
                end
            end
        end
    end

    psum_fifo #(
        .WIDTH (COLS*OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .push      (q_valid),
        .push_data (q_row),
        .pop       (pop),
        .head_data (out_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (count)
    );

    assign out_valid = !fifo_empty;
    assign stall_req = (count >= CW'(DEPTH-1));

endmodule

// File: tb/tb_psum_drain.sv
// tb/tb_psum_drain.sv - self-checking bench for psum_drain against a row-level reference model
module tb_psum_drain;

    localparam int COLS   = 8;
    localparam int PSUM_W = 24;
    localparam int OUT_W  = 8;
    localparam int DEPTH  = 4;
    localparam int SMAX   = 2**(OUT_W-1) - 1;
    localparam int SMIN   = -(2**(OUT_W-1));
`ifdef PSUM_DRAIN_ROUND_EN
    localparam logic [7:0] EXP_1000 = 8'd63;
`else
    localparam logic [7:0] EXP_1000 = 8'd62;
`endif

    logic                    clk;
    logic                    rst_n;
    logic                    clear;
    logic [4:0]              shift_amt;
    logic [COLS-1:0]         col_valid;
    logic [COLS*PSUM_W-1:0]  col_psum;
    logic                    out_valid;
    logic                    out_ready;
    logic [COLS*OUT_W-1:0]   out_data;
    logic                    stall_req;
    logic                    overflow;
    logic                    dup_err;

    int errors = 0;
    int checks = 0;
    int psv [COLS];
    int shv;
    logic [COLS*OUT_W-1:0] exp_q [$];
    logic [COLS*OUT_W-1:0] last_row;
    logic [COLS*OUT_W-1:0] tmp_row;

    psum_drain #(
        .COLS(COLS), .PSUM_W(PSUM_W), .OUT_W(OUT_W), .DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .shift_amt (shift_amt),
        .col_valid (col_valid),
        .col_psum  (col_psum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall_req (stall_req),
        .overflow  (overflow),
        .dup_err   (dup_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: real-valued shift with optional half-up rounding, then clamp.
    function automatic logic [7:0] ref_q(input int p, input int sh);
        int v;
        v = p;
`ifdef PSUM_DRAIN_ROUND_EN
        if (sh > 0) v = v + (1 << (sh - 1));
`endif
        v = v >>> sh;
        if (v > SMAX) v = SMAX;
        if (v < SMIN) v = SMIN;
        return v[7:0];
    endfunction

    function automatic logic [COLS*OUT_W-1:0] ref_row();
        logic [COLS*OUT_W-1:0] r;
        for (int c = 0; c < COLS; c++) r[c*OUT_W +: OUT_W] = ref_q(psv[c], shv);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rand_psum();
        int r;
        r = int'($urandom_range(0, 32'h00FF_FFFF)) - 32'h0080_0000;
        if ($urandom_range(0, 1) == 1) r = r >>> $urandom_range(4, 16);
        return r;
    endfunction

    // mode 0: all columns together; 1: column c at cycle c; 2: random offsets 0..3
    task automatic send_row(input int mode);
        int off [COLS];
        int last;
        last = 0;
        for (int c = 0; c < COLS; c++) begin
            off[c] = (mode == 0) ? 0 : (mode == 1) ? c : int'($urandom_range(0, 3));
            if (off[c] > last) last = off[c];
        end
        shift_amt = shv[4:0];
        for (int t = 0; t <= last; t++) begin
            col_valid = '0;
            for (int c = 0; c < COLS; c++) begin
                if (off[c] == t) begin
                    col_valid[c] = 1'b1;
                    col_psum[c*PSUM_W +: PSUM_W] = psv[c][PSUM_W-1:0];
                end
            end
            tick();
        end
        col_valid = '0;
    endtask

    task automatic drain_one(input string tag);
        int k;
        k = 0;
        while (!out_valid && k < 20) begin
            tick();
            k++;
        end
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_model_empty"}, 64'd0, 64'd1);
        end else begin
            tmp_row = exp_q.pop_front();
            check({tag, "_data"}, out_data, tmp_row);
        end
        last_row = out_data;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic rand_psv();
        for (int c = 0; c < COLS; c++) psv[c] = rand_psum();
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; shift_amt = '0; col_valid = '0; col_psum = '0; out_ready = 1'b0;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  out_data,       64'd0);
        check("rst_stall",     64'(stall_req), 64'd0);
        check("rst_overflow",  64'(overflow),  64'd0);
        check("rst_dup_err",   64'(dup_err),   64'd0);
        rst_n = 1'b1;
        tick();

        // Skewed row: psum c*16 at shift 4 gives bytes 0..7
        for (int c = 0; c < COLS; c++) psv[c] = c * 16;
        shv = 4;
        send_row(1);
        exp_q.push_back(ref_row());
        check("skew_valid_at_E", 64'(out_valid), 64'd0);
        tick();
        check("skew_valid_at_E1", 64'(out_valid), 64'd1);
        check("skew_row_const", out_data, 64'h0706_0504_0302_0100);
        drain_one("skew");
        check("skew_empty_after", 64'(out_valid), 64'd0);

        // Directed rounding/saturation rows
        psv[0] = 1000; psv[1] = -24; psv[2] = 100000; psv[3] = -100000;
        psv[4] = 8388607; psv[5] = -8388608; psv[6] = 16; psv[7] = -17;
        shv = 4;
        send_row(0);
        exp_q.push_back(ref_row());
        drain_one("dir_s4");
        check("rnd_1000_s4", 64'(last_row[7:0]),   64'(EXP_1000));
        check("sat_pos_s4",  64'(last_row[23:16]), 64'h7F);
        check("sat_neg_s4",  64'(last_row[31:24]), 64'h80);
        shv = 2;
        send_row(2);
        exp_q.push_back(ref_row());
        drain_one("dir_s2");
        check("neg24_s2", 64'(last_row[15:8]), 64'hFA);
        shv = 0;
        send_row(2);
        exp_q.push_back(ref_row());
        drain_one("dir_s0");
        check("max_s0", 64'(last_row[39:32]), 64'h7F);
        check("min_s0", 64'(last_row[47:40]), 64'h80);

        // Random rows, random shifts, random column skew
        for (int i = 0; i < 12; i++) begin
            rand_psv();
            shv = int'($urandom_range(0, PSUM_W - 1));
            send_row(2);
            exp_q.push_back(ref_row());
            drain_one("rand");
        end

        // Fill to DEPTH, then push while popping at full
        for (int i = 0; i < DEPTH; i++) begin
            rand_psv(); shv = int'($urandom_range(0, 12));
            send_row(0);
            exp_q.push_back(ref_row());
            tick();
        end
        check("full_stall", 64'(stall_req), 64'd1);
        rand_psv(); shv = 3;
        send_row(0);
        tmp_row = exp_q.pop_front();
        check("fullpp_head", out_data, tmp_row);
        exp_q.push_back(ref_row());
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("fullpp_overflow", 64'(overflow),  64'd0);
        check("fullpp_stall",    64'(stall_req), 64'd1);
        for (int i = 0; i < DEPTH; i++) drain_one("fullpp_drain");
        check("fullpp_empty", 64'(out_valid), 64'd0);
        check("fullpp_stall_low", 64'(stall_req), 64'd0);

        // Backpressure: five rows, fifth dropped
        for (int i = 0; i < 5; i++) begin
            rand_psv(); shv = int'($urandom_range(0, 10));
            send_row(0);
            if (i < DEPTH) exp_q.push_back(ref_row());
            tick();
            check("bp_stall",    64'(stall_req), 64'(i >= 2));
            check("bp_overflow", 64'(overflow),  64'(i == 4));
        end
        for (int i = 0; i < DEPTH; i++) drain_one("bp_drain");
        check("bp_empty", 64'(out_valid), 64'd0);

        // Duplicate capture on column 2: first value wins
        rand_psv(); shv = 5;
        shift_amt = 5'd5;
        col_valid = 8'h04; col_psum[2*PSUM_W +: PSUM_W] = psv[2][PSUM_W-1:0];
        tick();
        check("dup_before", 64'(dup_err), 64'd0);
        col_valid = 8'h04; col_psum[2*PSUM_W +: PSUM_W] = 24'h12_3456;
        tick();
        check("dup_after", 64'(dup_err), 64'd1);
        col_valid = 8'hFB;
        for (int c = 0; c < COLS; c++) if (c != 2) col_psum[c*PSUM_W +: PSUM_W] = psv[c][PSUM_W-1:0];
        tick();
        col_valid = '0;
        exp_q.push_back(ref_row());
        drain_one("dup_row");

        // clear: flushes a queued row and a partial row, keeps sticky flags
        rand_psv(); shv = 2;
        send_row(0);
        tick();
        col_valid = 8'h0F; col_psum = {COLS*PSUM_W{1'b1}};
        tick();
        col_valid = '0; clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_valid",    64'(out_valid), 64'd0);
        check("clr_overflow", 64'(overflow),  64'd1);
        check("clr_dup",      64'(dup_err),   64'd1);
        rand_psv(); shv = 6;
        send_row(2);
        exp_q.push_back(ref_row());
        drain_one("clr_next");

        // Asynchronous reset mid-row with a queued row
        rand_psv(); shv = 1;
        send_row(0);
        tick();
        col_valid = 8'h0F;
        tick();
        col_valid = '0;
        #3 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_out_data",  out_data,       64'd0);
        check("arst_stall",     64'(stall_req), 64'd0);
        check("arst_overflow",  64'(overflow),  64'd0);
        check("arst_dup",       64'(dup_err),   64'd0);
        #2 rst_n = 1'b1;
        tick();
        col_valid = 8'hF0;
        tick();
        col_valid = '0;
        for (int i = 0; i < 6; i++) tick();
        check("arst_no_row", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/psum_drain.md
# psum_drain

Collection end of the systolic partial-sum chain. Captures the skewed `partial_sum_out` values leaving the bottom row of the array, one per column, and re-assembles them into complete output rows. Each row is requantized from signed PSUM_W to signed OUT_W and buffered in a small FIFO. Rows are delivered to the writeback path over a valid/ready handshake, and a stall request goes back to the array controller before the FIFO can overflow.

## Interface
- COLS, 8, number of array columns
- PSUM_W, 24, signed partial-sum width
- OUT_W, 8, signed requantized output width
- DEPTH, 4, FIFO depth in rows (power of two, ≥2)
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous flush of the capture mask and FIFO; sticky flags are kept
- shift_amt  in  5  arithmetic right-shift applied before saturation, 0..PSUM_W-1
- col_valid  in  COLS  per-column strobe; column c's psum is valid this cycle
- col_psum  in  COLS*PSUM_W  column c occupies bits [c*PSUM_W +: PSUM_W], signed
- out_valid  out  1  FIFO head row available
- out_ready  in  1  consumer accepts the head row
- out_data  out  COLS*OUT_W  head row, column c at [c*OUT_W +: OUT_W]
- stall_req  out  1  FIFO count ≥ DEPTH-1
- overflow  out  1  sticky: a completed row was dropped because the FIFO was full
- dup_err  out  1  sticky: col_valid seen for a column already captured in the current row

## Operation
- Capture: on each edge, every column c with col_valid[c] and !mask[c] latches col_psum[c] into row_buf[c] and sets mask[c].
  - col_valid[c] with mask[c] already set is ignored and sets dup_err.
- Row complete when, after this edge's captures, all mask bits would be set.
  - On that edge, mask clears to 0, and row_buf with the final captures moves into the quantize register with the q_valid flag set.
  - Captures for the next row may start on the next cycle.
- Requantize, per column: v = psum >>> shift_amt (arithmetic shift), then saturate to [-(2^(OUT_W-1)), 2^(OUT_W-1)-1].
  - shift_amt is sampled in the cycle the row completes.
- FIFO write: when q_valid, the quantized row is pushed on the next edge.
  - If the FIFO is full and no pop occurs on that edge, the row is dropped and overflow is set.
- Pop: out_valid && out_ready advances the head.
  - Push and pop on the same edge when full is legal, and the count is unchanged.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- clear: mask, q_valid, pointers and count go to 0, and stall_req falls.
  - clear has priority over a same-cycle capture or push.
- No FSM beyond the mask, q_valid and count; the collect/complete behaviour is implied by the mask.

## Timing
- All outputs reset asynchronously on rst_n low:
  - out_valid=0, out_data=0, stall_req=0, overflow=0, dup_err=0.
  - Internal state (mask, q_valid, row_buf, pointers, count) resets to 0.
- Latency: the last column is captured on edge E, the quantize register loads on E, the FIFO is written on E+1, and out_valid is high from E+1 when the FIFO was empty.
- out_data is registered at the FIFO head and is stable while out_valid && !out_ready.
- stall_req is registered from count, so it lags a push by zero cycles after the edge.
- Reset asserted mid-row discards partial captures and FIFO contents.

## Configuration
- PSUM_DRAIN_ROUND_EN defined: round-half-up. Add 1<<(shift_amt-1) before the shift when shift_amt>0, using a PSUM_W+1 bit intermediate so there is no wrap.
- Undefined: plain truncation (floor via arithmetic shift).
- Saturation is unconditional in both builds.

## Structure
- Shared package accel_pkg holds PSUM_W, OUT_W and COLS defaults, plus the saturation limit constants.
- One sub-module, psum_fifo: a parameterized synchronous row FIFO with count, full/empty and registered head.
- Requantize is a function in accel_pkg, shared with other writeback paths.

## Test plan
- Skewed row: column c's strobe arrives c cycles after column 0, with psum[c]=c*16 and shift 4 → one row {0,1,..,7}, out_valid exactly at E+1.
- Rounding: psum 1000, shift 4 → 63 with PSUM_DRAIN_ROUND_EN, 62 without; psum -24, shift 2 → -6 in both builds.
- Saturation: psums 100000 / -100000 at shift 4 → 127 / -128; psum 0x7FFFFF at shift 0 → 127.
- Backpressure: out_ready=0 while 5 rows complete at DEPTH=4 → stall_req high after the 3rd push, the 5th row dropped, overflow=1, and the first 4 rows are read back in order.
- Full with simultaneous push/pop: at count=4 with out_ready=1 on the push edge → no drop, count stays 4, overflow stays 0.
- Duplicate and reset: col_valid[2] twice within one row → dup_err=1 and the second value is ignored; rst_n low mid-row → all outputs 0 immediately, and no row is emitted after release.
